// File: rtl/aes_arb_pkg.sv
// aes_arb_pkg: shared types and helpers for the AES core arbiter.
//   arb_state_t - arbiter FSM states
//   BLK_W       - AES block / key width in bits
//   MAX_REQ     - largest requester count the picker supports
//   pick_t      - round-robin search result (found flag + winner index)
//   rr_pick()   - round-robin priority search starting at ptr
package aes_arb_pkg;

    typedef enum logic [1:0] {IDLE, LOAD, WAIT, RESP} arb_state_t;

    localparam int BLK_W   = 128;
    localparam int MAX_REQ = 4;

    typedef struct packed {
        logic       found;
        logic [1:0] idx;
    } pick_t;

    // First set bit of valid at or after ptr, wrapping modulo nreq.
    // ptr must be < nreq; bits of valid at or above nreq are ignored.
    function automatic pick_t rr_pick(input logic [MAX_REQ-1:0] valid,
                                      input logic [1:0]         ptr,
                                      input int                 nreq);
        pick_t res;
        int    j;
        res = '0;
        for (int k = 0; k < MAX_REQ; k++) begin
            if (k < nreq) begin
                j = int'(ptr) + k;
                if (j >= nreq) j = j - nreq;
                if (!res.found && valid[j]) begin
                    res.found = 1'b1;
                    res.idx   = 2'(j);
                end
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/aes_rr_picker.sv
// aes_rr_picker: combinational round-robin winner search.
//   valid - request bits, one per requester
//   ptr   - requester with highest priority this cycle
//   found - at least one request is present
//   idx   - index of the winning requester (valid only when found=1)
module aes_rr_picker
    import aes_arb_pkg::*;
#(
    parameter int NREQ = 2
) (
    input  logic [NREQ-1:0]         valid,
    input  logic [$clog2(NREQ)-1:0] ptr,
    output logic                    found,
    output logic [$clog2(NREQ)-1:0] idx
);

    localparam int IW = $clog2(NREQ);

    pick_t pick;

    always_comb pick = rr_pick(MAX_REQ'(valid), 2'(ptr), NREQ);

    assign found = pick.found;
    assign idx   = IW'(pick.idx);

endmodule

// File: rtl/aes_core_arbiter.sv
// aes_core_arbiter: shares one AES cipher core between NREQ requesters.
// One job at a time: accept key/text from the round-robin winner, pulse
// core_ld, wait for core_done (or the watchdog), return the result to the
// same requester, then move the round-robin pointer past that owner.
//   clk, rst          - clock, asynchronous active-low reset
//   req_valid/ready   - job handshake per requester (ready is one-hot)
//   req_key/req_text  - per-requester 128-bit slices
//   rsp_valid/ready   - result handshake per requester (valid is one-hot)
//   rsp_text, rsp_err - shared result and watchdog-abort flag
//   core_ld/key/text  - cipher load pulse and operands
//   core_done/text_out- cipher completion pulse and result
//   busy, owner       - FSM not idle, current or last job owner
module aes_core_arbiter
    import aes_arb_pkg::*;
#(
    parameter int NREQ     = 2,
    parameter int MAX_WAIT = 64,
    parameter int CW       = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NREQ-1:0]         req_valid,
    output logic [NREQ-1:0]         req_ready,
    input  logic [NREQ*BLK_W-1:0]   req_key,
    input  logic [NREQ*BLK_W-1:0]   req_text,
    output logic [NREQ-1:0]         rsp_valid,
    input  logic [NREQ-1:0]         rsp_ready,
    output logic [BLK_W-1:0]        rsp_text,
    output logic                    rsp_err,
    output logic                    core_ld,
    output logic [BLK_W-1:0]        core_key,
    output logic [BLK_W-1:0]        core_text,
    input  logic                    core_done,
    input  logic [BLK_W-1:0]        core_text_out,
    output logic                    busy,
    output logic [$clog2(NREQ)-1:0] owner
);

    localparam int IW = $clog2(NREQ);

    arb_state_t     state, next_state;
    logic [IW-1:0]  rr_ptr;
    logic [IW-1:0]  win_idx;
    logic           win_found;
    logic [CW-1:0]  wd_cnt;
    logic           timeout;
    logic [IW-1:0]  owner_inc;

    aes_rr_picker #(.NREQ(NREQ)) u_picker (
        .valid (req_valid),
        .ptr   (rr_ptr),
        .found (win_found),
        .idx   (win_idx)
    );

    assign timeout   = (wd_cnt == CW'(MAX_WAIT - 1));
    assign owner_inc = (owner == IW'(NREQ - 1)) ? '0 : owner + IW'(1);
    assign busy      = (state != IDLE);

    always_comb begin
        // NOTE: every combinational output gets a default before the case
        // so no path leaves it unassigned (which would infer a latch).
        next_state = state;
        req_ready  = '0;
        rsp_valid  = '0;
        core_ld    = 1'b0;
        case (state)
            IDLE: begin
                if (win_found) begin
                    // Grant is combinational off req_valid, so it is masked
                    // by rst to keep every output low while reset is held.
                    req_ready[win_idx] = rst;
                    next_state         = LOAD;
                end
            end
            LOAD: begin
                core_ld    = 1'b1;
                next_state = WAIT;
            end
            WAIT: begin
                if (core_done || timeout) next_state = RESP;
            end
            RESP: begin
                rsp_valid[owner] = 1'b1;
                if (rsp_ready[owner]) next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every
    // register samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            rr_ptr    <= '0;
            owner     <= '0;
            wd_cnt    <= '0;
            core_key  <= '0;
            core_text <= '0;
            rsp_text  <= '0;
            rsp_err   <= 1'b0;
        end else begin
            state <= next_state;
            case (state)
                IDLE: begin
                    if (win_found) begin
                        owner     <= win_idx;
                        core_key  <= req_key[win_idx*BLK_W +: BLK_W];
                        core_text <= req_text[win_idx*BLK_W +: BLK_W];
                    end
                end
                LOAD: wd_cnt <= '0;
                WAIT: begin
                    wd_cnt <= wd_cnt + CW'(1);
                    // done takes priority over a timeout in the same cycle
                    if (core_done) begin
                        rsp_text <= core_text_out;
                        rsp_err  <= 1'b0;
                    end else if (timeout) begin
                        rsp_text <= '0;
                        rsp_err  <= 1'b1;
                    end
                end
                RESP: begin
                    if (rsp_ready[owner]) rr_ptr <= owner_inc;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_aes_core_arbiter.sv
// Directed bench for aes_core_arbiter with a behavioural cipher core whose
// done delay (cycles after core_ld, 0 = never) is programmable.
module tb_aes_core_arbiter;

    localparam int NREQ = 2, MAX_WAIT = 64, CW = 8;

    localparam logic [127:0] FIPS_KEY = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] FIPS_PT  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] FIPS_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

    logic           clk = 1'b0;
    logic           rst;
    logic [1:0]     req_valid, req_ready, rsp_valid, rsp_ready;
    logic [255:0]   req_key, req_text;
    logic [127:0]   rsp_text, core_key, core_text, core_text_out;
    logic           rsp_err, core_ld, core_done, busy;
    logic [0:0]     owner;

    always #5 clk = ~clk;

    aes_core_arbiter #(.NREQ(NREQ), .MAX_WAIT(MAX_WAIT), .CW(CW)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_key(req_key), .req_text(req_text),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_text(rsp_text), .rsp_err(rsp_err),
        .core_ld(core_ld), .core_key(core_key), .core_text(core_text),
        .core_done(core_done), .core_text_out(core_text_out),
        .busy(busy), .owner(owner)
    );

    // Behavioural cipher: FIPS-197 vector is known, anything else maps to
    // key ^ (text with its halves swapped).
    function automatic logic [127:0] core_model(input logic [127:0] k, t);
        if (k == FIPS_KEY && t == FIPS_PT) return FIPS_CT;
        return k ^ {t[63:0], t[127:64]};
    endfunction

    int   core_delay = 1;
    int   core_cnt;
    logic force_done = 1'b0;

    always @(posedge clk or negedge rst) begin
        if (!rst)               core_cnt <= 0;
        else if (core_ld)       core_cnt <= core_delay;
        else if (core_cnt > 0)  core_cnt <= core_cnt - 1;
    end
    assign core_done     = (core_cnt == 1) || force_done;
    assign core_text_out = core_model(core_key, core_text);

    int total = 0, bad = 0;
    int cyc = 0;
    always @(posedge clk) cyc++;

    // Protocol monitor, sampled mid-low-phase after inputs have settled.
    int   viol = 0, ld_count = 0, ld_cyc = 0;
    logic hs_last = 1'b0;
    int   grants[$];
    always begin
        @(negedge clk);
        #3;
        if ($countones(req_ready) > 1 || $countones(rsp_valid) > 1) viol++;
        if (req_ready != 2'b00 && busy) viol++;
        if (core_ld) begin
            ld_count++;
            ld_cyc = cyc;
            if (!hs_last) viol++;
        end
        hs_last = |(req_valid & req_ready);
        if (hs_last) grants.push_back(req_ready[1] ? 1 : 0);
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    // Runs one job for requester r and returns what was observed.
    task automatic do_job(input int r, input logic [127:0] key, text,
                          input int delay, output logic [1:0] grant,
                          output logic [1:0] rv, output logic [127:0] rtext,
                          output logic rerr, output logic [0:0] rown,
                          output int lat, output bit ok);
        ok = 1'b0;
        core_delay = delay;
        req_key[128*r +: 128]  = key;
        req_text[128*r +: 128] = text;
        req_valid = '0;
        req_valid[r] = 1'b1;
        #1 grant = req_ready;
        tick();
        req_valid = '0;
        for (int i = 0; i < 300; i++) begin
            if (rsp_valid != 2'b00) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        lat = cyc - ld_cyc;
        rv = rsp_valid; rtext = rsp_text; rerr = rsp_err; rown = owner;
        rsp_ready = rsp_valid;
        tick();
        rsp_ready = '0;
    endtask

    task automatic test_reset();
        tick();
        total++; if (req_ready !== 2'b00) begin bad++; $display("FAIL reset_req_ready: got %b want 00", req_ready); end
        total++; if (rsp_valid !== 2'b00) begin bad++; $display("FAIL reset_rsp_valid: got %b want 00", rsp_valid); end
        total++; if (rsp_text !== '0) begin bad++; $display("FAIL reset_rsp_text: got %h want 0", rsp_text); end
        total++; if ({rsp_err, core_ld, busy, owner} !== 4'b0) begin bad++; $display("FAIL reset_flags: got %b want 0000", {rsp_err, core_ld, busy, owner}); end
        total++; if (core_key !== '0 || core_text !== '0) begin bad++; $display("FAIL reset_core_ops: got %h/%h want 0", core_key, core_text); end
        req_valid = 2'b11;
        #1;
        total++; if (req_ready !== 2'b00) begin bad++; $display("FAIL reset_ready_masked: got %b want 00", req_ready); end
        req_valid = 2'b00;
        rst = 1'b1;
        tick();
    endtask

    task automatic test_fips();
        logic [1:0] g, rv; logic [127:0] t; logic e; logic [0:0] o; int lat; bit ok; int ld0;
        ld0 = ld_count;
        do_job(0, FIPS_KEY, FIPS_PT, 10, g, rv, t, e, o, lat, ok);
        total++; if (!ok) begin bad++; $display("FAIL fips_rsp_timeout: got no rsp_valid want rsp_valid"); end
        total++; if (g !== 2'b01) begin bad++; $display("FAIL fips_grant: got %b want 01", g); end
        total++; if (rv !== 2'b01) begin bad++; $display("FAIL fips_rsp_valid: got %b want 01", rv); end
        total++; if (t !== FIPS_CT) begin bad++; $display("FAIL fips_text: got %h want %h", t, FIPS_CT); end
        total++; if (e !== 1'b0 || o !== 1'b0) begin bad++; $display("FAIL fips_err_owner: got %b/%b want 0/0", e, o); end
        total++; if (lat != 11) begin bad++; $display("FAIL fips_latency: got %0d want 11", lat); end
        total++; if (ld_count - ld0 != 1) begin bad++; $display("FAIL fips_ld_pulses: got %0d want 1", ld_count - ld0); end
        // rr_ptr should now be 1: requester 1 wins a tie. Valid drops before
        // the edge, so nothing is accepted.
        req_valid = 2'b11;
        #1;
        total++; if (req_ready !== 2'b10) begin bad++; $display("FAIL rr_after_fips: got %b want 10", req_ready); end
        req_valid = 2'b00;
        tick();
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL dropped_req_busy: got %b want 0", busy); end
    endtask

    task automatic test_watchdog();
        logic [1:0] g, rv; logic [127:0] t, k, p; logic e; logic [0:0] o; int lat; bit ok;
        k = 128'h2b7e151628aed2a6abf7158809cf4f3c;
        p = 128'h3243f6a8885a308d313198a2e0370734;
        do_job(1, k, p, 0, g, rv, t, e, o, lat, ok);
        total++; if (!ok || rv !== 2'b10) begin bad++; $display("FAIL wd_rsp_valid: got %b want 10", rv); end
        total++; if (e !== 1'b1 || t !== '0) begin bad++; $display("FAIL wd_abort: got err=%b text=%h want err=1 text=0", e, t); end
        // 64 WAIT cycles (counter 0..63) follow the ld cycle; RESP is next.
        total++; if (lat != 65) begin bad++; $display("FAIL wd_latency: got %0d want 65", lat); end
        do_job(1, p, k, 5, g, rv, t, e, o, lat, ok);
        total++; if (!ok || e !== 1'b0 || t !== core_model(p, k)) begin bad++; $display("FAIL wd_recover: got err=%b text=%h want err=0 text=%h", e, t, core_model(p, k)); end
        total++; if (lat != 6 || o !== 1'b1) begin bad++; $display("FAIL wd_recover_lat_owner: got %0d/%b want 6/1", lat, o); end
    endtask

    task automatic test_collision();
        logic [1:0] g, rv; logic [127:0] t, k, p; logic e; logic [0:0] o; int lat; bit ok;
        k = 128'hffeeddccbbaa99887766554433221100;
        p = 128'h0123456789abcdef0011223344556677;
        // done lands exactly on counter == MAX_WAIT-1
        do_job(0, k, p, 64, g, rv, t, e, o, lat, ok);
        total++; if (!ok || e !== 1'b0 || t !== core_model(k, p)) begin bad++; $display("FAIL collision: got err=%b text=%h want err=0 text=%h", e, t, core_model(k, p)); end
        total++; if (lat != 65) begin bad++; $display("FAIL collision_latency: got %0d want 65", lat); end
    endtask

    task automatic test_spurious_done();
        logic [127:0] held;
        held = rsp_text;
        force_done = 1'b1;
        tick();
        force_done = 1'b0;
        tick();
        total++; if (busy !== 1'b0 || rsp_valid !== 2'b00) begin bad++; $display("FAIL idle_done: got busy=%b rsp_valid=%b want 0/00", busy, rsp_valid); end
        total++; if (rsp_text !== held) begin bad++; $display("FAIL idle_done_hold: got %h want %h", rsp_text, held); end
    endtask

    task automatic test_late_done();
        logic [1:0] g, rv; logic [127:0] t; logic e; logic [0:0] o; int lat; bit ok;
        // done one cycle too late: watchdog fires, later done hits RESP
        do_job(1, 128'h1, 128'h2, 65, g, rv, t, e, o, lat, ok);
        total++; if (!ok || e !== 1'b1 || t !== '0 || lat != 65) begin bad++; $display("FAIL late_done: got err=%b text=%h lat=%0d want 1/0/65", e, t, lat); end
    endtask

    task automatic test_fairness();
        int nresp;
        logic [3:0] order;
        grants.delete();
        core_delay = 3;
        req_key  = {128'haaaa, 128'h5555};
        req_text = {128'h1234, 128'h9876};
        req_valid = 2'b11;
        nresp = 0;
        for (int i = 0; i < 200 && nresp < 4; i++) begin
            tick();
            if (rsp_valid != 2'b00) begin
                rsp_ready = rsp_valid;
                tick();
                rsp_ready = '0;
                nresp++;
                if (nresp == 4) req_valid = 2'b00;
            end
        end
        total++; if (nresp != 4 || grants.size() != 4) begin bad++; $display("FAIL fair_count: got %0d resp %0d grants want 4/4", nresp, grants.size()); end
        order = '0;
        for (int i = 0; i < 4 && i < grants.size(); i++) order[i] = grants[i][0];
        total++; if (order !== 4'b1010) begin bad++; $display("FAIL fair_order: got %b want 1010 (0,1,0,1)", order); end
    endtask

    task automatic test_back_to_back();
        logic [127:0] vt;
        logic stable;
        bit ok;
        core_delay = 4;
        req_key  = {128'hc0ffee, 128'hbeef};
        req_text = {128'hf00d, 128'hcafe};
        req_valid = 2'b11;
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            tick();
            if (rsp_valid != 2'b00) begin ok = 1'b1; break; end
        end
        total++; if (!ok || rsp_valid !== 2'b01) begin bad++; $display("FAIL bp_owner: got %b want 01", rsp_valid); end
        vt = rsp_text;
        total++; if (vt !== core_model(128'hbeef, 128'hcafe)) begin bad++; $display("FAIL bp_text: got %h want %h", vt, core_model(128'hbeef, 128'hcafe)); end
        stable = 1'b1;
        for (int i = 0; i < 10; i++) begin
            rsp_ready = 2'b10;   // non-owner ready must be ignored
            tick();
            if (rsp_valid !== 2'b01 || rsp_text !== vt || req_ready !== 2'b00) stable = 1'b0;
        end
        total++; if (!stable) begin bad++; $display("FAIL bp_stable: got change under backpressure want stable"); end
        rsp_ready = 2'b01;
        tick();
        rsp_ready = 2'b00;
        total++; if (req_ready !== 2'b10) begin bad++; $display("FAIL bp_next_grant: got %b want 10", req_ready); end
        req_valid = 2'b00;
        tick();
    endtask

    task automatic test_reset_mid_wait();
        core_delay = 0;
        req_key[255:128]  = 128'h77;
        req_text[255:128] = 128'h88;
        req_valid = 2'b10;
        tick();              // accepted, now LOAD
        tick();              // WAIT
        req_valid = 2'b11;
        #2 rst = 1'b0;
        #1;
        total++; if ({req_ready, rsp_valid, rsp_err, core_ld, busy, owner} !== 8'b0) begin bad++; $display("FAIL rst_mid_flags: got %b want 0", {req_ready, rsp_valid, rsp_err, core_ld, busy, owner}); end
        total++; if (core_key !== '0 || core_text !== '0 || rsp_text !== '0) begin bad++; $display("FAIL rst_mid_data: got %h/%h/%h want 0", core_key, core_text, rsp_text); end
        tick();
        tick();
        rst = 1'b1;
        #1;
        total++; if (req_ready !== 2'b01) begin bad++; $display("FAIL rst_first_grant: got %b want 01", req_ready); end
        req_valid = 2'b00;
        tick();
    endtask

    task automatic test_monitor();
        total++; if (viol != 0) begin bad++; $display("FAIL protocol_monitor: got %0d violations want 0", viol); end
    endtask

    initial begin
        rst = 1'b0;
        req_valid = '0; rsp_ready = '0;
        req_key = '0; req_text = '0;
        test_reset();
        test_fips();
        test_watchdog();
        test_collision();
        test_spurious_done();
        test_late_done();
        test_fairness();
        test_back_to_back();
        test_reset_mid_wait();
        test_monitor();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish want finish");
        $fatal(1, "timeout");
    end

endmodule
